// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, write-data select codes and FSM states
// for the control sequencer and its return stack.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_SYS  = 4'h0;
  localparam logic [3:0] OP_LI   = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h2;
  localparam logic [3:0] OP_JZ   = 4'h3;
  localparam logic [3:0] OP_JNZ  = 4'h4;
  localparam logic [3:0] OP_CALL = 4'h5;
  localparam logic [3:0] OP_RET  = 4'h6;
  localparam logic [3:0] OP_IN   = 4'h7;

  localparam logic [15:0] HALT_WORD = 16'h0FFF;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_IMM = 2'b01;
  localparam logic [1:0] WD_IO  = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_WAIT_IO,
    ST_HALT
  } state_t;

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses; the pointer saturates instead of wrapping,
// so callers must gate push with full and pop with empty.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   sp;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx;

  assign wr_idx = sp[AW-1:0];
  assign rd_idx = wr_idx - 1'b1;
  assign full   = (sp == (AW+1)'(DEPTH));
  assign empty  = (sp == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + 1'b1;
    end else if (pop && !empty) begin
      sp <= sp - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !full) begin
      mem[wr_idx] <= data;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// PC, zero flag, return stack and instruction decode for
// the 16-bit ALU/regfile datapath, with IO stall and timeout.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int STACK_DEPTH = 4,
  parameter int IO_TIMEOUT  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [15:0]     instr,
  input  logic            zero,
  input  logic            io_ready,
  output logic [PC_W-1:0] pc,
  output logic [2:0]      op_alu,
  output logic [3:0]      ra1,
  output logic [3:0]      ra2,
  output logic [3:0]      wa,
  output logic            we3,
  output logic [1:0]      wd_sel,
  output logic [7:0]      imm,
  output logic            io_req,
  output logic [1:0]      io_port,
  output logic            halted,
  output logic            stack_err,
  output logic            io_err
);

  localparam int CW = $clog2(IO_TIMEOUT + 1);

  state_t          state;
  logic            zflag;
  logic [CW-1:0]   cnt;
  logic [3:0]      opc;
  logic            is_alu, is_li, is_jmp, is_jz, is_jnz;
  logic            is_call, is_ret, is_in, is_halt;
  logic            run, active, push, pop, full, empty;
  logic [PC_W-1:0] pc_inc, tgt, top;

  assign opc     = instr[15:12];
  assign is_alu  = instr[15];
  assign is_li   = (opc == OP_LI);
  assign is_jmp  = (opc == OP_JMP);
  assign is_jz   = (opc == OP_JZ);
  assign is_jnz  = (opc == OP_JNZ);
  assign is_call = (opc == OP_CALL);
  assign is_ret  = (opc == OP_RET);
  assign is_in   = (opc == OP_IN);
  assign is_halt = (instr == HALT_WORD);

  assign pc_inc = pc + 1'b1;
  assign tgt    = instr[PC_W-1:0];
  assign run    = !reset && (state == ST_RUN);
  assign active = !reset && (state != ST_HALT);
  assign push   = run && is_call && !full;
  assign pop    = run && is_ret && !empty;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PC_W)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .data  (pc_inc),
    .top   (top),
    .full  (full),
    .empty (empty)
  );

  // WAIT_IO keeps decoding the held IN word since pc is frozen there
  always_comb begin
    op_alu  = instr[14:12];
    ra1     = instr[11:8];
    ra2     = instr[7:4];
    wa      = instr[3:0];
    imm     = instr[11:4];
    io_port = instr[5:4];
    we3     = 1'b0;
    wd_sel  = WD_ALU;
    io_req  = 1'b0;
    if (active) begin
      unique case (1'b1)
        is_alu: we3 = 1'b1;
        is_li: begin
          we3    = 1'b1;
          wd_sel = WD_IMM;
        end
        is_in: begin
          io_req = 1'b1;
          we3    = io_ready;
          wd_sel = WD_IO;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_RUN;
      pc        <= '0;
      zflag     <= 1'b0;
      cnt       <= '0;
      halted    <= 1'b0;
      stack_err <= 1'b0;
      io_err    <= 1'b0;
    end else begin
      unique case (state)
        ST_RUN: begin
          unique case (1'b1)
            is_halt: begin
              state  <= ST_HALT;
              halted <= 1'b1;
            end
            is_alu: begin
              zflag <= zero;
              pc    <= pc_inc;
            end
            is_jmp: pc <= tgt;
            is_jz:  pc <= zflag ? tgt : pc_inc;
            is_jnz: pc <= zflag ? pc_inc : tgt;
            is_call: begin
              pc <= full ? pc_inc : tgt;
              if (full) stack_err <= 1'b1;
            end
            is_ret: begin
              pc <= empty ? pc_inc : top;
              if (empty) stack_err <= 1'b1;
            end
            is_in: begin
              if (io_ready) begin
                pc <= pc_inc;
              end else begin
                state <= ST_WAIT_IO;
                cnt   <= CW'(1);
              end
            end
            default: pc <= pc_inc;
          endcase
        end
        ST_WAIT_IO: begin
          if (io_ready) begin
            pc    <= pc_inc;
            state <= ST_RUN;
            cnt   <= '0;
          end else if (cnt == CW'(IO_TIMEOUT - 1)) begin
            // this cycle is the IO_TIMEOUT-th with io_req high
            io_err <= 1'b1;
            pc     <= pc_inc;
            state  <= ST_RUN;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HALT: ;
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed and random checks of control_sequencer against a
// queue-based behavioural model driven from a modelled ROM.
module tb_control_sequencer;

  localparam int PC_W = 10;
  localparam int SD   = 4;
  localparam int TO   = 16;
  localparam int ROMN = 1 << PC_W;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            zero = 1'b0;
  logic            io_ready = 1'b0;
  logic [15:0]     instr;
  logic [PC_W-1:0] pc;
  logic [2:0]      op_alu;
  logic [3:0]      ra1, ra2, wa;
  logic            we3;
  logic [1:0]      wd_sel;
  logic [7:0]      imm;
  logic            io_req;
  logic [1:0]      io_port;
  logic            halted, stack_err, io_err;

  logic [15:0] rom [ROMN];

  assign instr = rom[pc];

  always #5 clk = ~clk;

  control_sequencer #(
    .PC_W        (PC_W),
    .STACK_DEPTH (SD),
    .IO_TIMEOUT  (TO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .zero      (zero),
    .io_ready  (io_ready),
    .pc        (pc),
    .op_alu    (op_alu),
    .ra1       (ra1),
    .ra2       (ra2),
    .wa        (wa),
    .we3       (we3),
    .wd_sel    (wd_sel),
    .imm       (imm),
    .io_req    (io_req),
    .io_port   (io_port),
    .halted    (halted),
    .stack_err (stack_err),
    .io_err    (io_err)
  );

  int ncmp = 0;
  int nerr = 0;
  int n_we = 0;

  int m_pc;
  bit m_z, m_halt, m_serr, m_ierr;
  int m_wcnt;
  int m_stk[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc   = 0;
    m_z    = 0;
    m_halt = 0;
    m_serr = 0;
    m_ierr = 0;
    m_wcnt = 0;
    m_stk.delete();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < ROMN; i++) rom[i] = 16'h0000;
  endtask

  task automatic step(input bit r, input bit z, input bit rdy);
    logic [15:0] w;
    int op, tgt, nxt;
    bit e_we, e_req;
    logic [1:0] e_sel;
    reset = r;
    zero = z;
    io_ready = rdy;
    #2;
    w = rom[m_pc];
    op = int'(w[15:12]);
    e_we = 0;
    e_req = 0;
    e_sel = 2'b00;
    if (!r && !m_halt) begin
      if (w[15]) begin
        e_we = 1;
      end else if (op == 1) begin
        e_we = 1;
        e_sel = 2'b01;
      end else if (op == 7) begin
        e_req = 1;
        e_we = rdy;
        e_sel = 2'b10;
      end
    end
    chk("pc", 32'(pc), 32'(m_pc));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("stack_err", 32'(stack_err), 32'(m_serr));
    chk("io_err", 32'(io_err), 32'(m_ierr));
    chk("we3", 32'(we3), 32'(e_we));
    chk("io_req", 32'(io_req), 32'(e_req));
    if (we3 === 1'b1) n_we++;
    if (e_we) begin
      chk("wd_sel", 32'(wd_sel), 32'(e_sel));
      chk("wa", 32'(wa), 32'(w[3:0]));
    end
    if (e_we && w[15]) begin
      chk("op_alu", 32'(op_alu), 32'(w[14:12]));
      chk("ra1", 32'(ra1), 32'(w[11:8]));
      chk("ra2", 32'(ra2), 32'(w[7:4]));
    end
    if (e_we && op == 1) chk("imm", 32'(imm), 32'(w[11:4]));
    if (e_req) chk("io_port", 32'(io_port), 32'(w[5:4]));
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
    end else if (!m_halt) begin
      tgt = int'(w[9:0]);
      nxt = (m_pc + 1) % ROMN;
      if (w == 16'h0FFF) begin
        m_halt = 1;
      end else if (w[15]) begin
        m_z = z;
        m_pc = nxt;
      end else begin
        case (op)
          2: m_pc = tgt;
          3: m_pc = m_z ? tgt : nxt;
          4: m_pc = m_z ? nxt : tgt;
          5: begin
            if (m_stk.size() == SD) begin
              m_serr = 1;
              m_pc = nxt;
            end else begin
              m_stk.push_back(nxt);
              m_pc = tgt;
            end
          end
          6: begin
            if (m_stk.size() == 0) begin
              m_serr = 1;
              m_pc = nxt;
            end else begin
              m_pc = m_stk.pop_back();
            end
          end
          7: begin
            if (rdy) begin
              m_wcnt = 0;
              m_pc = nxt;
            end else begin
              m_wcnt++;
              if (m_wcnt == TO) begin
                m_ierr = 1;
                m_wcnt = 0;
                m_pc = nxt;
              end
            end
          end
          default: m_pc = nxt;
        endcase
      end
    end
  endtask

  initial begin
    int we_before;
    clear_rom();
    model_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_stack_err", 32'(stack_err), 32'h0);
    chk("rst_io_err", 32'(io_err), 32'h0);
    chk("rst_we3", 32'(we3), 32'h0);
    chk("rst_io_req", 32'(io_req), 32'h0);

    // ALU stream, then reset mid-stream
    for (int i = 0; i < 8; i++) rom[i] = 16'h8000 | 16'(i * 16'h1111);
    for (int i = 0; i < 5; i++) step(0, i[0], 0);
    chk("t1_pc5", 32'(pc), 32'h5);
    step(1, 0, 0);
    chk("t1_pc_after_rst", 32'(pc), 32'h0);

    // JZ / JNZ use the registered flag
    clear_rom();
    rom[0] = 16'h8012;
    rom[1] = 16'h33A0;
    step(0, 1, 0);
    step(0, 0, 0);
    chk("t2_jz_taken", 32'(pc), 32'h3A0);
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("t2_jz_not", 32'(pc), 32'h2);
    rom[1] = 16'h43A0;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("t2_jnz_taken", 32'(pc), 32'h3A0);
    step(1, 0, 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("t2_jnz_not", 32'(pc), 32'h2);

    // nested calls overflow, then returns underflow
    clear_rom();
    rom[0]    = 16'h5010;
    rom[10'h10] = 16'h5020;
    rom[10'h20] = 16'h5030;
    rom[10'h30] = 16'h5040;
    rom[10'h40] = 16'h5050;
    rom[10'h41] = 16'h6000;
    rom[10'h31] = 16'h6000;
    rom[10'h21] = 16'h6000;
    rom[10'h11] = 16'h6000;
    rom[1]    = 16'h6000;
    step(1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    chk("t3_four_pushes", 32'(pc), 32'h40);
    step(0, 0, 0);
    chk("t3_full_pc", 32'(pc), 32'h41);
    chk("t3_full_err", 32'(stack_err), 32'h1);
    step(0, 0, 0);
    chk("t3_ret1", 32'(pc), 32'h31);
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    chk("t3_ret4", 32'(pc), 32'h1);
    step(0, 0, 0);
    chk("t3_empty_pc", 32'(pc), 32'h2);

    // IN stalls until ready
    clear_rom();
    rom[0] = 16'h7025;
    step(1, 0, 0);
    we_before = n_we;
    for (int i = 0; i < 3; i++) step(0, 0, 0);
    step(0, 0, 1);
    chk("t4_we_pulses", 32'(n_we - we_before), 32'h1);
    chk("t4_pc", 32'(pc), 32'h1);

    // IN timeout, then HALT freezes
    rom[1] = 16'h0FFF;
    step(1, 0, 0);
    we_before = n_we;
    for (int i = 0; i < TO; i++) step(0, 0, 0);
    chk("t5_io_err", 32'(io_err), 32'h1);
    chk("t5_pc", 32'(pc), 32'h1);
    chk("t5_no_we", 32'(n_we - we_before), 32'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    chk("t5_halted", 32'(halted), 32'h1);
    chk("t5_frozen", 32'(pc), 32'h1);

    // CALL at top of memory, then reset in WAIT_IO
    clear_rom();
    rom[0]     = 16'h23FF;
    rom[10'h3FF] = 16'h5005;
    rom[5]     = 16'h6000;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    chk("t6_call_pc", 32'(pc), 32'h5);
    step(0, 0, 0);
    chk("t6_ret_wrap", 32'(pc), 32'h0);
    rom[0] = 16'h7010;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("t6_rst_io_req", 32'(io_req), 32'h0);
    rom[0] = 16'h0000;
    step(0, 0, 0);
    step(0, 0, 0);

    // random program and inputs
    for (int i = 0; i < ROMN; i++) begin
      rom[i] = ($urandom_range(0, 63) == 0) ? 16'h0FFF : 16'($urandom);
    end
    step(1, 0, 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
